// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcode constants and FSM state encoding shared by the ALU arbiter
package alu_pkg;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_XOR  = 3'b100;
    localparam logic [2:0] OP_SHL  = 3'b101;
    localparam logic [2:0] OP_SHR  = 3'b110;
    localparam logic [2:0] OP_ADD2 = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/alu_8bit.sv
// rtl/alu_8bit.sv - 8-bit combinational ALU with carry-out
module alu_8bit
    import alu_pkg::*;
(
    input  logic [7:0] i_a,
    input  logic [7:0] i_b,
    input  logic [2:0] i_op,
    output logic [7:0] o_result,
    output logic       o_carry
);

    logic [8:0] w_wide;

    always_comb begin
        w_wide = 9'd0;
        case (i_op)
            OP_ADD, OP_ADD2: w_wide = {1'b0, i_a} + {1'b0, i_b};
            // carry is "no borrow": b == 0 always sets it
            OP_SUB:          w_wide = {1'b0, i_a} + {1'b0, ~i_b} + 9'd1;
            OP_AND:          w_wide = {1'b0, i_a & i_b};
            OP_OR:           w_wide = {1'b0, i_a | i_b};
            OP_XOR:          w_wide = {1'b0, i_a ^ i_b};
            OP_SHL:          w_wide = {1'b0, i_a[6:0], 1'b0};
            OP_SHR:          w_wide = {2'b00, i_a[7:1]};
            default:         w_wide = 9'd0;
        endcase
    end

    assign o_result = w_wide[7:0];
    assign o_carry  = w_wide[8];

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-requester arbiter sharing one ALU, one operation in flight
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int RR_EN = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0_valid,
    output logic       req0_ready,
    input  logic [7:0] req0_a,
    input  logic [7:0] req0_b,
    input  logic [2:0] req0_op,
    input  logic       req1_valid,
    output logic       req1_ready,
    input  logic [7:0] req1_a,
    input  logic [7:0] req1_b,
    input  logic [2:0] req1_op,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic       rsp_id,
    output logic [7:0] rsp_result,
    output logic       rsp_carry,
    output logic [7:0] ops_count
);

    state_t     r_state;
    state_t     w_next;
    logic       r_last;
    logic [7:0] r_a;
    logic [7:0] r_b;
    logic [2:0] r_op;
    logic       r_id;
    logic [7:0] r_result;
    logic       r_carry;
    logic [7:0] r_ops_count;
    logic       w_grant_id;
    logic       w_accept;
    logic       w_rsp_hs;
    logic [7:0] w_alu_result;
    logic       w_alu_carry;

    always_comb begin
        if (req0_valid && req1_valid) begin
            w_grant_id = (RR_EN != 0) ? ~r_last : 1'b0;
        end else begin
            w_grant_id = ~req0_valid;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ready is gated by rst so it stays low throughout reset
    always_comb begin
        w_next     = r_state;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        rsp_valid  = 1'b0;
        w_accept   = 1'b0;
        w_rsp_hs   = 1'b0;
        case (r_state)
            IDLE: begin
                if ((req0_valid || req1_valid) && !rst) begin
                    w_accept   = 1'b1;
                    req0_ready = ~w_grant_id;
                    req1_ready = w_grant_id;
                    w_next     = EXEC;
                end
            end
            EXEC: w_next = RESP;
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    w_rsp_hs = 1'b1;
                    w_next   = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last      <= 1'b1;
            r_a         <= 8'd0;
            r_b         <= 8'd0;
            r_op        <= 3'd0;
            r_id        <= 1'b0;
            r_result    <= 8'd0;
            r_carry     <= 1'b0;
            r_ops_count <= 8'd0;
        end else begin
            if (w_accept) begin
                r_id <= w_grant_id;
                r_a  <= w_grant_id ? req1_a  : req0_a;
                r_b  <= w_grant_id ? req1_b  : req0_b;
                r_op <= w_grant_id ? req1_op : req0_op;
            end
            if (r_state == EXEC) begin
                r_result <= w_alu_result;
                r_carry  <= w_alu_carry;
            end
            if (w_rsp_hs) begin
                r_ops_count <= r_ops_count + 8'd1;
                r_last      <= r_id;
            end
        end
    end

    alu_8bit u_alu (
        .i_a      (r_a),
        .i_b      (r_b),
        .i_op     (r_op),
        .o_result (w_alu_result),
        .o_carry  (w_alu_carry)
    );

    assign rsp_id     = r_id;
    assign rsp_result = r_result;
    assign rsp_carry  = r_carry;
    assign ops_count  = r_ops_count;

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter RR_EN, default 1, meaning 1 = round-robin arbitration, 0 = fixed priority with requester 0 highest.
REQ-002 clk  input  1  single clock for all state; rising-edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 req0_valid  input  1  requester 0 has an operation pending.
REQ-005 req0_ready  output  1  requester 0 operation accepted this cycle.
REQ-006 req0_a, req0_b  input  8 each  requester 0 operands.
REQ-007 req0_op  input  3  requester 0 ALU opcode.
REQ-008 req1_valid / req1_ready / req1_a / req1_b / req1_op  same as REQ-004..007, for requester 1.
REQ-009 rsp_valid  output  1  result available.
REQ-010 rsp_ready  input  1  consumer accepts result.
REQ-011 rsp_id  output  1  requester that issued the result.
REQ-012 rsp_result  output  8  ALU result.
REQ-013 rsp_carry  output  1  ALU carry-out.
REQ-014 ops_count  output  8  count of completed response handshakes.

Function
REQ-015 FSM states: IDLE, EXEC, RESP; the block SHALL hold at most one operation in flight.
REQ-016 IDLE: if any reqN_valid is high, the block SHALL grant one requester, pulse its reqN_ready for exactly that cycle, capture its a/b/op/id into registers and move to EXEC; otherwise remain in IDLE.
REQ-017 reqN_ready SHALL be high only in IDLE and only for the granted requester; a handshake is valid & ready in the same cycle.
REQ-018 Both valid with RR_EN=1: grant the requester not granted last; with RR_EN=0: grant requester 0.
REQ-019 EXEC: the block SHALL drive the captured operands into the ALU, register result and carry, and move to RESP.
REQ-020 RESP: rsp_valid SHALL be high and rsp_id/result/carry stable until rsp_ready is high; on handshake go to IDLE, increment ops_count, and update the last-grant pointer.
REQ-021 Latency: acceptance in cycle N gives rsp_valid in cycle N+2; minimum issue interval is 3 cycles.
REQ-022 Opcodes: 000 add, 001 sub, 010 AND, 011 OR, 100 XOR, 101 shift-left-1, 110 shift-right-1, 111 add.
REQ-023 Add: {carry,result} = 9-bit a+b.
REQ-024 Sub: {carry,result} = 9-bit a + (8-bit two's complement of b); b=0 SHALL give carry=1.
REQ-025 Logic and shift ops SHALL give carry=0; shifted-in bits are 0.
REQ-026 ops_count SHALL wrap 255 -> 0 with no flag.
REQ-027 Requesters SHALL hold valid and operands stable until ready; a non-granted requester SHALL wait without loss.
REQ-028 rsp_ready high outside RESP SHALL have no effect.

Reset
REQ-029 On rst the block SHALL asynchronously enter IDLE and clear rsp_valid, reqN_ready, rsp_id, rsp_result, rsp_carry and ops_count to 0.
REQ-030 On rst the last-grant pointer SHALL be set to requester 1, so requester 0 wins the first tie.
REQ-031 rst asserted during EXEC or RESP SHALL discard the in-flight operation, and no response SHALL be produced for it.

Structure
REQ-032 A shared package alu_pkg SHALL hold the opcode constants (OP_ADD..OP_ADD2) and the FSM state enumeration.
REQ-033 The block SHALL contain exactly one sub-module: one instance of the team's ALU_8bit combinational ALU, driven only from the captured registers.

Verification
REQ-034 Only req0_valid, a=5, b=3, op=001 -> req0_ready pulses once, two cycles later rsp_valid=1, rsp_id=0, result=0x02, carry=1.
REQ-035 Both valid from reset, RR_EN=1, rsp_ready=1 -> grants alternate 0,1,0,1; each rsp_id matches its grant.
REQ-036 Both valid, RR_EN=0 -> requester 0 is always granted and requester 1 is never granted while req0_valid is held.
REQ-037 a=0xFF, b=0x01, op=000 -> result=0x00, carry=1; op=101 on a=0x81 -> result=0x02, carry=0.
REQ-038 rsp_ready held low 5 cycles in RESP -> rsp_valid and rsp fields stable, no new ready; 256 handshakes -> ops_count wraps to 0.
REQ-039 rst asserted during EXEC -> rsp_valid stays 0, ops_count=0; after release requester 0 wins the tie.
